// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: first-word-fall-through read stage holding up to two words between FIFO memory and consumer.
module fifo_rd_fwft #(
  parameter int DATA_W = 8
) (
  input  logic              i_rClk,
  input  logic              i_rRst,
  input  logic              i_rEmpty,
  output logic              o_rInc,
  input  logic [DATA_W-1:0] i_rData,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data,
  output logic [1:0]        o_count
);
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state;
  logic [DATA_W-1:0] tail;
  logic push, pop;
  always_comb begin
    o_rInc  = !i_rRst && !i_rEmpty && (state != TWO);
    push    = o_rInc;
    o_valid = state != EMPTY;
    pop     = o_valid && i_ready;
    o_count = state;
  end
  always_ff @(posedge i_rClk) begin
    if (i_rRst) begin
      state  <= EMPTY;
      o_data <= '0;
      tail   <= '0;
    end else begin
      unique case (state)
        EMPTY: if (push) begin
          state  <= ONE;
          o_data <= i_rData;
        end
        ONE: if (push && !pop) begin
          state <= TWO;
          tail  <= i_rData;
        end else if (push) begin
          o_data <= i_rData;
        end else if (pop) begin
          state <= EMPTY;
        end
        TWO: if (pop) begin
          state  <= ONE;
          o_data <= tail;
        end
        default: state <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb_fifo_rd_fwft: directed vector table plus streaming and random scoreboard sequences.
module tb_fifo_rd_fwft;
  logic       i_rClk = 1'b0;
  logic       i_rRst = 1'b1;
  logic       i_rEmpty = 1'b1;
  logic       o_rInc;
  logic [7:0] i_rData = 8'h00;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic [7:0] o_data;
  logic [1:0] o_count;
  int checks = 0;
  int errors = 0;
  fifo_rd_fwft #(.DATA_W(8)) dut (
    .i_rClk(i_rClk), .i_rRst(i_rRst), .i_rEmpty(i_rEmpty), .o_rInc(o_rInc),
    .i_rData(i_rData), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_count(o_count)
  );
  always #5 i_rClk = ~i_rClk;
  typedef struct {
    logic       rst;
    logic       emp;
    logic [7:0] d;
    logic       rdy;
    logic       x_inc;
    logic       x_val;
    logic [7:0] x_dat;
    logic [1:0] x_cnt;
  } vec_t;
  vec_t vt[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input logic rst, input logic emp, input logic [7:0] d, input logic rdy);
    i_rRst = rst;
    i_rEmpty = emp;
    i_rData = d;
    i_ready = rdy;
    #1;
  endtask
  task automatic tick();
    @(posedge i_rClk);
    #1;
  endtask
  initial begin
    logic [7:0] q[$];
    logic [7:0] nxt;
    logic exp_inc, psh, pp;
    //          rst   emp   data   rdy   inc   val   o_data cnt
    vt.push_back('{1'b1, 1'b0, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0});
    vt.push_back('{1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 2'd1});
    vt.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 2'd0});
    vt.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'hA5, 2'd0});
    vt.push_back('{1'b0, 1'b0, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 2'd1});
    vt.push_back('{1'b0, 1'b0, 8'h02, 1'b0, 1'b1, 1'b1, 8'h01, 2'd2});
    vt.push_back('{1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 2'd2});
    vt.push_back('{1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b1, 8'h01, 2'd2});
    vt.push_back('{1'b0, 1'b0, 8'h03, 1'b1, 1'b0, 1'b1, 8'h02, 2'd1});
    vt.push_back('{1'b0, 1'b0, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 2'd1});
    vt.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h03, 2'd0});
    vt.push_back('{1'b0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b1, 8'h11, 2'd1});
    vt.push_back('{1'b0, 1'b0, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 2'd2});
    vt.push_back('{1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0});
    vt.push_back('{1'b0, 1'b0, 8'h44, 1'b0, 1'b1, 1'b1, 8'h44, 2'd1});
    vt.push_back('{1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h44, 2'd0});
    tick();
    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].rst, vt[i].emp, vt[i].d, vt[i].rdy);
      chk($sformatf("vec%0d o_rInc", i), {31'd0, o_rInc}, {31'd0, vt[i].x_inc});
      tick();
      chk($sformatf("vec%0d o_valid", i), {31'd0, o_valid}, {31'd0, vt[i].x_val});
      chk($sformatf("vec%0d o_data", i), {24'd0, o_data}, {24'd0, vt[i].x_dat});
      chk($sformatf("vec%0d o_count", i), {30'd0, o_count}, {30'd0, vt[i].x_cnt});
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 8'h10 + 8'(i), 1'b1);
      chk("stream o_rInc", {31'd0, o_rInc}, 32'd1);
      tick();
      chk("stream o_valid", {31'd0, o_valid}, 32'd1);
      chk("stream o_data", {24'd0, o_data}, 32'h10 + i);
      chk("stream o_count", {30'd0, o_count}, 32'd1);
    end
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    tick();
    chk("stream drained", {31'd0, o_valid}, 32'd0);
    nxt = 8'h00;
    for (int c = 0; c < 10000; c++) begin
      drive(1'b0, ($urandom_range(0, 3) == 0), nxt, 1'($urandom_range(0, 1)));
      exp_inc = !i_rEmpty && (q.size() < 2);
      chk("rand o_rInc", {31'd0, o_rInc}, {31'd0, exp_inc});
      psh = exp_inc;
      pp = (q.size() != 0) && i_ready;
      tick();
      if (pp) void'(q.pop_front());
      if (psh) begin
        q.push_back(nxt);
        nxt++;
      end
      chk("rand o_count", {30'd0, o_count}, q.size());
      chk("rand o_valid", {31'd0, o_valid}, {31'd0, q.size() != 0});
      if (q.size() != 0) chk("rand o_data", {24'd0, o_data}, {24'd0, q[0]});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
